// File: rtl/wbs_pwm_pkg.sv
// Shared register map and CTRL layout for the wbs_pwm PWM front end.
// Imported by the top and its prescaler so both agree on addresses and limits.
package wbs_pwm_pkg;

    localparam logic [3:0] ADR_DIV   = 4'd0;
    localparam logic [3:0] ADR_CTRL  = 4'd1;
    localparam logic [3:0] ADR_DUTY0 = 4'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_PEND_BIT = 1;

    localparam int CHANNELS_MAX = 14;

    function automatic logic [7:0] ctrl_word(input logic en, input logic pend);
        logic [7:0] w;
        w                = 8'h00;
        w[CTRL_EN_BIT]   = en;
        w[CTRL_PEND_BIT] = pend;
        return w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler and shared free-running PWM phase counter.
// tick fires when the prescaler equals div; wrap marks the tick that rolls 255 to 0.
module pwm_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick,
    output logic       wrap,
    output logic [7:0] pwm_counter
);

    logic [7:0] presc;

    assign tick = en && (presc == div);
    assign wrap = tick && (pwm_counter == 8'hFF);

    // A div lowered below presc lets presc run on through 255 and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc       <= 8'h00;
            pwm_counter <= 8'h00;
        end else begin
            presc <= tick ? 8'h00 : presc + 8'h01;
            if (tick) begin
                pwm_counter <= pwm_counter + 8'h01;
            end
        end
    end

endmodule

// File: rtl/wbs_pwm.sv
// Wishbone pipelined slave holding PWM shadow duty registers.
// Shadow values reach the channel stages only at the period boundary or while disabled.
module wbs_pwm
    import wbs_pwm_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                  wbs_clk_i,
    input  logic                  wbs_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_adr_i,
    input  logic [7:0]            wbs_dat_i,
    output logic [7:0]            wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_stall_o,
    output logic [7:0]            pwm_counter,
    output logic [CHANNELS-1:0]   ch_stb_o,
    output logic [8*CHANNELS-1:0] ch_dat_o
);

    if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("wbs_pwm: CHANNELS out of range");
    end

    logic                div_q;
    logic [7:0]          div_r;
    logic                en_q;
    logic [7:0]          shadow_q [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic                ack_q;
    logic                tick;
    logic                wrap;
    logic                push;
    logic                wr;
    logic [CHANNELS-1:0] duty_wr;
    logic [7:0]          rd_data;

    assign div_q       = 1'b0;
    assign wbs_stall_o = div_q;

    pwm_prescaler u_prescaler (
        .clk         (wbs_clk_i),
        .rst         (wbs_rst_i),
        .en          (en_q),
        .div         (div_r),
        .tick        (tick),
        .wrap        (wrap),
        .pwm_counter (pwm_counter)
    );

    assign wr   = wbs_stb_i && wbs_we_i;
    assign push = !en_q || wrap;

    always_comb begin
        duty_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_wr[i] = wr && (int'(wbs_adr_i) == int'(ADR_DUTY0) + i);
        end
    end

    // Reads see register contents from before any write in the same cycle.
    always_comb begin
        rd_data = 8'h00;
        if (wbs_adr_i == ADR_DIV) begin
            rd_data = div_r;
        end else if (wbs_adr_i == ADR_CTRL) begin
            rd_data = ctrl_word(en_q, |pend_q);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(wbs_adr_i) == int'(ADR_DUTY0) + i) begin
                    rd_data = shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            ack_q     <= 1'b0;
            wbs_dat_o <= 8'h00;
            div_r     <= 8'h00;
            en_q      <= 1'b0;
            pend_q    <= '0;
            ch_stb_o  <= '0;
            ch_dat_o  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            ack_q     <= wbs_stb_i;
            wbs_dat_o <= (wbs_stb_i && !wbs_we_i) ? rd_data : 8'h00;

            if (wr && wbs_adr_i == ADR_DIV) begin
                div_r <= wbs_dat_i;
            end
            if (wr && wbs_adr_i == ADR_CTRL) begin
                en_q <= wbs_dat_i[CTRL_EN_BIT];
            end

            // A write colliding with a push re-arms the flag so the new value goes next time.
            pend_q   <= (pend_q & ~{CHANNELS{push}}) | duty_wr;
            ch_stb_o <= push ? pend_q : '0;

            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_wr[i]) begin
                    shadow_q[i] <= wbs_dat_i;
                end
                if (push && pend_q[i]) begin
                    ch_dat_o[8*i +: 8] <= shadow_q[i];
                end
            end
        end
    end

    // Masking with reset keeps a request aborted by reset from being acknowledged.
    assign wbs_ack_o = ack_q && !wbs_rst_i;

endmodule
